// File: rtl/axi_llc_way_req_arb.sv
// -----------------------------------------------------------------------------
// axi_llc_way_req_arb
//
// Round-robin arbiter that collects data-way requests from NumReq cache units
// into a single output register feeding the data way.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   req_i        : per-unit request payload (way_inp_t)
//   req_valid_i  : per-unit request valid
//   req_ready_o  : per-unit accept (at most one bit high)
//   oup_o        : registered request toward the data way
//   oup_valid_o  : oup_o holds a valid request
//   oup_ready_i  : data way accepts oup_o
// -----------------------------------------------------------------------------

// Minimal stand-in for the static LLC configuration type referenced by Cfg.
package axi_llc_pkg;
  typedef struct packed {
    logic [31:0] set_associativity;
    logic [31:0] num_lines;
    logic [31:0] num_blocks;
  } llc_cfg_t;
endpackage

module axi_llc_way_req_arb #(
  parameter axi_llc_pkg::llc_cfg_t Cfg       = axi_llc_pkg::llc_cfg_t'{default: '0},
  parameter type                   way_inp_t = logic,
  parameter int unsigned           NumReq    = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  way_inp_t          req_i [NumReq],
  input  logic [NumReq-1:0] req_valid_i,
  output logic [NumReq-1:0] req_ready_o,
  output way_inp_t          oup_o,
  output logic              oup_valid_o,
  input  logic              oup_ready_i
);

  localparam int unsigned IdxW = $clog2(NumReq);
  typedef logic [IdxW-1:0] idx_t;

  idx_t     rr_q, rr_d;
  idx_t     gnt_idx, cand_idx;
  logic     gnt_any;
  logic     can_load;
  logic     hs;
  way_inp_t oup_q;
  logic     valid_q;

  // Configuration is carried for interface compatibility only.
  logic cfg_unused;
  assign cfg_unused = ^Cfg;

  assign oup_o       = oup_q;
  assign oup_valid_o = valid_q;

  // Register may load whenever it is empty or being drained this cycle.
  assign can_load = ~valid_q | oup_ready_i;

  // Cyclic first-one search starting at rr_q; depends on valids and rr_q only.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand_idx = idx_t'((32'(rr_q) + k) % NumReq);
      if (!gnt_any && req_valid_i[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  assign hs = can_load & gnt_any;

  always_comb begin
    req_ready_o = '0;
    if (hs) req_ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    rr_d = rr_q;
    if (hs) rr_d = (gnt_idx == idx_t'(NumReq - 1)) ? '0 : idx_t'(gnt_idx + 1'b1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      oup_q   <= '0;
      rr_q    <= '0;
    end else begin
      if (can_load) valid_q <= gnt_any;
      if (hs)       oup_q   <= req_i[gnt_idx];
      rr_q <= rr_d;
    end
  end

`ifndef SYNTHESIS
  // A requester that is not accepted must hold valid and payload.
  for (genvar g = 0; g < NumReq; g++) begin : gen_proto_chk
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_valid_i[g] && !req_ready_o[g]) |=> (req_valid_i[g] && $stable(req_i[g])))
      else $error("axi_llc_way_req_arb: requester %0d dropped valid or changed payload before handshake", g);
  end
`endif

endmodule

// File: tb/tb_axi_llc_way_req_arb.sv
// -----------------------------------------------------------------------------
// tb_axi_llc_way_req_arb
//
// Directed and randomized self-checking bench for axi_llc_way_req_arb with
// NumReq = 3 and a full data-way request struct as payload.
// -----------------------------------------------------------------------------
module tb_axi_llc_way_req_arb;

  localparam int unsigned N = 3;

  typedef struct packed {
    logic [1:0]  cache_unit;
    logic [2:0]  way_ind;
    logic [15:0] line_addr;
    logic [3:0]  blk_offset;
    logic        we;
    logic [31:0] data;
    logic [3:0]  strb;
  } way_t;

  logic           clk = 1'b0;
  logic           rst_n;
  way_t           req [N];
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  way_t           oup;
  logic           oup_valid;
  logic           oup_ready;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  axi_llc_way_req_arb #(
    .way_inp_t (way_t),
    .NumReq    (N)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .oup_o       (oup),
    .oup_valid_o (oup_valid),
    .oup_ready_i (oup_ready)
  );

  always #5 clk = ~clk;

  function automatic way_t mk(input int unsigned u, input int unsigned seq);
    way_t p;
    p.cache_unit = 2'(u);
    p.way_ind    = 3'(seq);
    p.line_addr  = 16'(seq * 7 + u);
    p.blk_offset = 4'(seq);
    p.we         = seq[0];
    p.data       = {8'(u), 24'(seq)};
    p.strb       = 4'(seq ^ u);
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    way_t z;
    z = '0;
    #2;
    n_checks++; if (oup_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", oup_valid); else n_pass++;
    n_checks++; if (oup !== z) $display("FAIL rst_payload: got %h want %h", oup, z); else n_pass++;
    n_checks++; if (req_ready !== 3'b000) $display("FAIL rst_ready_idle: got %b want 000", req_ready); else n_pass++;
    oup_ready = 1'b1;
    req_valid = 3'b111;
    #1;
    n_checks++; if (req_ready !== 3'b001) $display("FAIL rst_ready_comb: got %b want 001", req_ready); else n_pass++;
    req_valid = 3'b000;
    tick();
    tick();
    n_checks++; if (oup_valid !== 1'b0) $display("FAIL rst_hold_valid: got %b want 0", oup_valid); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int unsigned cnt [N];
    int unsigned seqn [N];
    int unsigned exp_idx;
    for (int unsigned i = 0; i < N; i++) begin
      cnt[i]  = 2;
      seqn[i] = 10 * i;
    end
    oup_ready = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        req_valid[i] = (cnt[i] != 0);
        req[i]       = mk(i, seqn[i]);
      end
      #1;
      exp_idx = k % N;
      n_checks++; if (req_ready !== 3'(1 << exp_idx)) $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, 3'(1 << exp_idx)); else n_pass++;
      for (int unsigned i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          cnt[i]--;
          seqn[i]++;
        end
      end
      tick();
      n_checks++; if (oup_valid !== 1'b1 || oup.cache_unit !== 2'(exp_idx))
        $display("FAIL rr_out[%0d]: got v=%b unit=%0d want v=1 unit=%0d", k, oup_valid, oup.cache_unit, exp_idx); else n_pass++;
      n_checks++; if (oup !== mk(exp_idx, seqn[exp_idx] - 1)) $display("FAIL rr_payload[%0d]: got %h want %h", k, oup, mk(exp_idx, seqn[exp_idx] - 1)); else n_pass++;
    end
    req_valid = 3'b000;
    #1;
    n_checks++; if (req_ready !== 3'b000) $display("FAIL rr_idle_ready: got %b want 000", req_ready); else n_pass++;
    tick();
    n_checks++; if (oup_valid !== 1'b0) $display("FAIL rr_drain: got %b want 0", oup_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    way_t p0, p1;
    p0 = mk(0, 100);
    p1 = mk(1, 101);
    oup_ready = 1'b0;
    req[0]    = p0;
    req_valid = 3'b001;
    #1;
    n_checks++; if (req_ready !== 3'b001) $display("FAIL bp_fill_ready: got %b want 001", req_ready); else n_pass++;
    tick();
    req_valid = 3'b000;
    n_checks++; if (oup_valid !== 1'b1 || oup !== p0) $display("FAIL bp_fill_out: got v=%b %h want v=1 %h", oup_valid, oup, p0); else n_pass++;
    req[1]    = p1;
    req_valid = 3'b010;
    #1;
    n_checks++; if (req_ready !== 3'b000) $display("FAIL bp_stall_ready0: got %b want 000", req_ready); else n_pass++;
    tick();
    n_checks++; if (oup_valid !== 1'b1 || oup !== p0) $display("FAIL bp_hold1: got v=%b %h want v=1 %h", oup_valid, oup, p0); else n_pass++;
    #1;
    n_checks++; if (req_ready !== 3'b000) $display("FAIL bp_stall_ready1: got %b want 000", req_ready); else n_pass++;
    tick();
    n_checks++; if (oup_valid !== 1'b1 || oup !== p0) $display("FAIL bp_hold2: got v=%b %h want v=1 %h", oup_valid, oup, p0); else n_pass++;
    oup_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 3'b010) $display("FAIL bp_release_ready: got %b want 010", req_ready); else n_pass++;
    tick();
    req_valid = 3'b000;
    n_checks++; if (oup_valid !== 1'b1 || oup !== p1) $display("FAIL bp_b2b_load: got v=%b %h want v=1 %h", oup_valid, oup, p1); else n_pass++;
  endtask

  task automatic test_wrap();
    req[0]    = mk(0, 200);
    req[1]    = mk(1, 201);
    req_valid = 3'b011;
    #1;
    n_checks++; if (req_ready !== 3'b001) $display("FAIL wrap_grant: got %b want 001", req_ready); else n_pass++;
    tick();
    n_checks++; if (oup !== mk(0, 200)) $display("FAIL wrap_out: got %h want %h", oup, mk(0, 200)); else n_pass++;
    req[0]    = mk(0, 202);
    req_valid = 3'b011;
    #1;
    n_checks++; if (req_ready !== 3'b010) $display("FAIL wrap_rr_next: got %b want 010", req_ready); else n_pass++;
    tick();
    n_checks++; if (oup !== mk(1, 201)) $display("FAIL wrap_out2: got %h want %h", oup, mk(1, 201)); else n_pass++;
    req_valid = 3'b001;
    #1;
    n_checks++; if (req_ready !== 3'b001) $display("FAIL wrap_again: got %b want 001", req_ready); else n_pass++;
    tick();
    n_checks++; if (oup !== mk(0, 202)) $display("FAIL wrap_out3: got %h want %h", oup, mk(0, 202)); else n_pass++;
    req_valid = 3'b000;
    tick();
    n_checks++; if (oup_valid !== 1'b0) $display("FAIL wrap_drain: got %b want 0", oup_valid); else n_pass++;
  endtask

  task automatic test_single();
    way_t p;
    p      = mk(1, 300);
    p.we   = 1'b1;
    p.strb = 4'b1010;
    p.data = 32'hDEAD_BEEF;
    req[1]    = p;
    req_valid = 3'b010;
    oup_ready = 1'b1;
    #1;
    n_checks++; if (req_ready !== 3'b010) $display("FAIL single_ready: got %b want 010", req_ready); else n_pass++;
    tick();
    req_valid = 3'b000;
    n_checks++; if (oup_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", oup_valid); else n_pass++;
    n_checks++; if (oup !== p) $display("FAIL single_payload: got %h want %h", oup, p); else n_pass++;
    tick();
    n_checks++; if (oup_valid !== 1'b0) $display("FAIL single_pulse1: got %b want 0", oup_valid); else n_pass++;
    tick();
    n_checks++; if (oup_valid !== 1'b0) $display("FAIL single_pulse2: got %b want 0", oup_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    way_t p, z;
    z = '0;
    p = mk(1, 400);
    oup_ready = 1'b0;
    req[1]    = p;
    req_valid = 3'b010;
    #1;
    n_checks++; if (req_ready !== 3'b010) $display("FAIL rm_ready: got %b want 010", req_ready); else n_pass++;
    tick();
    req_valid = 3'b000;
    n_checks++; if (oup_valid !== 1'b1 || oup !== p) $display("FAIL rm_full: got v=%b %h want v=1 %h", oup_valid, oup, p); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (oup_valid !== 1'b0) $display("FAIL rm_async_valid: got %b want 0", oup_valid); else n_pass++;
    n_checks++; if (oup !== z) $display("FAIL rm_async_payload: got %h want %h", oup, z); else n_pass++;
    tick();
    tick();
    rst_n     = 1'b1;
    oup_ready = 1'b1;
    n_checks++; if (oup_valid !== 1'b0) $display("FAIL rm_after_release: got %b want 0", oup_valid); else n_pass++;
    req[1]    = mk(1, 401);
    req[2]    = mk(2, 402);
    req_valid = 3'b110;
    #1;
    n_checks++; if (req_ready !== 3'b010) $display("FAIL rm_first_from0: got %b want 010", req_ready); else n_pass++;
    tick();
    n_checks++; if (oup !== mk(1, 401)) $display("FAIL rm_first_out: got %h want %h", oup, mk(1, 401)); else n_pass++;
    req_valid = 3'b100;
    #1;
    n_checks++; if (req_ready !== 3'b100) $display("FAIL rm_second_ready: got %b want 100", req_ready); else n_pass++;
    tick();
    n_checks++; if (oup !== mk(2, 402)) $display("FAIL rm_second_out: got %h want %h", oup, mk(2, 402)); else n_pass++;
    req_valid = 3'b000;
    tick();
    n_checks++; if (oup_valid !== 1'b0) $display("FAIL rm_drain: got %b want 0", oup_valid); else n_pass++;
  endtask

  task automatic test_random();
    way_t        sbq [$];
    way_t        exp_p;
    int unsigned wait_h [N];
    int unsigned rs [N];
    logic [N-1:0] hs_vec;
    bit          allow_new;
    for (int unsigned i = 0; i < N; i++) begin
      rs[i]     = 1000 + 100000 * i;
      wait_h[i] = 0;
    end
    req_valid = '0;
    for (int unsigned c = 0; c < 10000 + 4 * N; c++) begin
      allow_new = (c < 10000);
      for (int unsigned i = 0; i < N; i++) begin
        if (allow_new && !req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req[i]       = mk(i, rs[i]);
          wait_h[i]    = 0;
        end
      end
      oup_ready = allow_new ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      n_checks++;
      if ($countones(req_ready) > 1 || (req_ready & ~req_valid) != '0)
        $display("FAIL rnd_ready_shape[%0d]: got ready=%b valid=%b want onehot subset", c, req_ready, req_valid);
      else n_pass++;
      if (oup_valid && oup_ready) begin
        n_checks++;
        if (sbq.size() == 0) $display("FAIL rnd_dup[%0d]: got extra %h want none", c, oup);
        else begin
          exp_p = sbq.pop_front();
          if (oup !== exp_p) $display("FAIL rnd_order[%0d]: got %h want %h", c, oup, exp_p); else n_pass++;
        end
      end
      hs_vec = req_valid & req_ready;
      for (int unsigned i = 0; i < N; i++) begin
        if (hs_vec[i]) begin
          n_checks++;
          if (wait_h[i] >= N) $display("FAIL rnd_starve[%0d]: got wait=%0d want <%0d", i, wait_h[i], N); else n_pass++;
          sbq.push_back(req[i]);
          rs[i]++;
          for (int unsigned j = 0; j < N; j++)
            if (j != i && req_valid[j]) wait_h[j]++;
        end
      end
      tick();
      req_valid = req_valid & ~hs_vec;
    end
    n_checks++; if (req_valid !== '0) $display("FAIL rnd_pending: got %b want 000", req_valid); else n_pass++;
    n_checks++; if (sbq.size() != 0 || oup_valid !== 1'b0) $display("FAIL rnd_lost: got %0d queued v=%b want 0 v=0", sbq.size(), oup_valid); else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    oup_ready = 1'b0;
    for (int unsigned i = 0; i < N; i++) req[i] = mk(i, 0);
    test_reset();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_single();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
